// File: rtl/addersub_rr_arbiter.sv
// addersub_rr_arbiter: round-robin sharing of one addersub_32 unit among NREQ requesters.
// Latency: one cycle from the req handshake to a visible response; 1 op/cycle throughput.
// Backpressure: a held response (rsp_valid & !rsp_ready) blocks all grants; drain and refill can happen in the same cycle.
// Optional macro ADDSUB_ARB_PRIO0_EN: requester 0 gets absolute priority and does not advance rr_ptr.
// Parameter contract: IDW must equal $clog2(NREQ), NREQ in 2..8.

// Combinational add/subtract with a set-less-than flag in bit WIDTH.
// op[0]=1 adds, op[0]=0 subtracts; op[1] selects signed extension; op[2] (SLT/SLTU) forces subtract.
module addersub_32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             slt_o
);

   logic             sub;
   logic             sgn;
   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   sum;

   // One extra bit: for subtracts it is the borrow (unsigned) or true sign (signed), i.e. the less-than flag.
   always_comb begin
      sub      = ~op_i[0] | op_i[2];
      sgn      = op_i[1];
      a_ext    = {sgn & a_i[WIDTH-1], a_i};
      b_ext    = {sgn & b_i[WIDTH-1], b_i};
      sum      = sub ? (a_ext - b_ext) : (a_ext + b_ext);
      result_o = sum[WIDTH-1:0];
      slt_o    = sum[WIDTH];
   end

endmodule

module addersub_rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_opA,
   input  logic [NREQ*WIDTH-1:0] req_opB,
   input  logic [NREQ*3-1:0]     req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_slt
);

   // Response register and round-robin pointer.
   logic             rsp_valid_q,  rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q,     rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_slt_q,    rsp_slt_d;
   logic [IDW-1:0]   rr_ptr_q,     rr_ptr_d;

   // Arbitration results.
   logic             accept_ok;
   logic             grant_vld;
   logic [IDW-1:0]   grant_idx;
   logic             prio_hit;
   logic             accept;
   logic [IDW:0]     idx_ext;

   // Operands of the winner.
   logic [WIDTH-1:0] mux_a;
   logic [WIDTH-1:0] mux_b;
   logic [2:0]       mux_op;
   logic [WIDTH-1:0] add_result;
   logic             add_slt;

   assign accept_ok = ~rsp_valid_q | rsp_ready;

   // Pick the first valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx_ext   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_ext = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx_ext >= (IDW+1)'(NREQ)) begin
            idx_ext = idx_ext - (IDW+1)'(NREQ);
         end
         if (!grant_vld && req_valid[idx_ext[IDW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = idx_ext[IDW-1:0];
         end
      end
`ifdef ADDSUB_ARB_PRIO0_EN
      // Requester 0 overrides the rotation; requesters 1..NREQ-1 may starve while it stays valid.
      prio_hit = req_valid[0];
      if (prio_hit) begin
         grant_vld = 1'b1;
         grant_idx = '0;
      end
`else
      prio_hit = 1'b0;
`endif
   end

   // Accept only out of reset and when the response slot can load this cycle.
   always_comb begin
      accept    = resetn & accept_ok & grant_vld;
      req_ready = '0;
      if (accept) begin
         req_ready = NREQ'(1) << grant_idx;
      end
   end

   // Route the granted requester's operands to the shared adder.
   always_comb begin
      mux_a  = '0;
      mux_b  = '0;
      mux_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            mux_a  = req_opA[i*WIDTH +: WIDTH];
            mux_b  = req_opB[i*WIDTH +: WIDTH];
            mux_op = req_op[i*3 +: 3];
         end
      end
   end

   addersub_32 #(
      .WIDTH (WIDTH)
   ) u_addersub (
      .a_i      (mux_a),
      .b_i      (mux_b),
      .op_i     (mux_op),
      .result_o (add_result),
      .slt_o    (add_slt)
   );

   // Next state: load on accept, clear valid on a plain drain, otherwise hold.
   always_comb begin
      rsp_valid_d  = rsp_valid_q & ~rsp_ready;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_slt_d    = rsp_slt_q;
      rr_ptr_d     = rr_ptr_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant_idx;
         rsp_result_d = add_result;
         rsp_slt_d    = add_slt;
         if (!prio_hit) begin
            rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset; a pending response is discarded by reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_slt_q    <= 1'b0;
         rr_ptr_q     <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_slt_q    <= rsp_slt_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_slt    = rsp_slt_q;

endmodule
